led_blink_multi: RTL and testbench
==================================

LED_BLINK_MULTI -- requirements
Module: led_blink_multi

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000, input clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 4, number of LED channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 8, width of burst count.
REQ-004 SHALL have port i_clock, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_enable, input, 1, global output gate.
REQ-007 SHALL have port i_cfg_we, input, 1, config write strobe, one cycle per write.
REQ-008 SHALL have port i_cfg_ch, input, 4, target channel index.
REQ-009 SHALL have port i_cfg_mode, input, 2, mode: 00 OFF, 01 ON, 10 BLINK, 11 BURST.
REQ-010 SHALL have port i_cfg_rate, input, 2, rate select: 00 100 Hz, 01 50 Hz, 10 10 Hz, 11 1 Hz.
REQ-011 SHALL have port i_cfg_count, input, CNT_W, burst pulse count.
REQ-012 SHALL have port o_led, output, NUM_CH, LED drives.
REQ-013 SHALL have port o_busy, output, NUM_CH, channel in BURST and not finished.
REQ-014 SHALL have port o_done, output, NUM_CH, one-cycle burst-complete pulse.

Function
REQ-015 SHALL run four free-running rate dividers, half-period H = CLK_HZ/(2*rate), each counting 0..H-1, asserting a one-cycle tick at H-1, wrapping to 0, and flipping its toggle bit.
REQ-016 Each divider SHALL use its own H; exact periods: 2H cycles per output period.
REQ-017 Dividers SHALL run regardless of i_enable, channel mode or config writes.
REQ-018 A write with i_cfg_we=1 and i_cfg_ch<NUM_CH SHALL load mode, rate, count into that channel on that edge; i_cfg_ch>=NUM_CH ignored.
REQ-019 OFF: o_led[ch]=0; ON: o_led[ch]=1, both starting the cycle after the write.
REQ-020 BLINK: o_led[ch] SHALL equal the selected divider's toggle bit (combinational follow, phase-locked across channels).
REQ-021 BURST states per channel: ARM, HIGH, LOW; entered as ARM, o_busy=1.
REQ-022 ARM->HIGH on first tick of selected rate; HIGH->LOW on next tick; LOW->HIGH on next tick while pulses remaining >0, else burst ends.
REQ-023 Burst SHALL emit exactly i_cfg_count high phases of H cycles each, separated by H-cycle low phases.
REQ-024 At burst end (final LOW tick) SHALL pulse o_done[ch] for one cycle, clear o_busy[ch], set mode OFF.
REQ-025 BURST with count 0 SHALL end the cycle after the write: o_done pulse, mode OFF, o_led never high.
REQ-026 A write to a busy channel SHALL replace its config immediately with no o_done pulse; a write in the same cycle as burst end wins, no o_done.
REQ-027 o_led SHALL equal channel drive AND i_enable; i_enable does not pause bursts.
REQ-028 Channels SHALL be independent; one write affects only its channel.

Reset
REQ-029 Asserting i_reset_n low SHALL immediately clear dividers, toggles, all channel modes to OFF, o_led=0, o_busy=0, o_done=0, aborting bursts without o_done.
REQ-030 After release, first tick of each divider SHALL occur H cycles later.

Structure
REQ-031 Package led_blink_pkg SHALL hold mode encoding, rate encoding, rate-Hz table and the half-period function.
REQ-032 Sub-module led_rate_div SHALL implement one divider (parameter H; outputs tick, toggle), instanced four times.

Verification
REQ-033 Defaults, channel 0 BLINK rate 00 -> o_led[0] period exactly 250 cycles, 125 high; rate 11 -> 25000 cycles.
REQ-034 Channel 1 BURST rate 00 count 3 -> three 125-cycle highs, 125-cycle lows, o_done[1] one cycle at end, o_busy[1] low after, mode OFF.
REQ-035 BURST count 0 -> o_done pulse the next cycle, o_led stays 0.
REQ-036 Rewrite channel mid-burst to ON -> o_led high next cycle, no o_done.
REQ-037 i_enable=0 during BLINK on all channels -> o_led all 0; re-enable -> phase unchanged from divider count.
REQ-038 i_reset_n low mid-burst -> all outputs 0 immediately; no o_done after release.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared encodings and divider sizing for the multi-channel LED blinker.
package led_blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      RATE_100HZ = 2'b00,
      RATE_50HZ  = 2'b01,
      RATE_10HZ  = 2'b10,
      RATE_1HZ   = 2'b11
   } rate_e;

   typedef enum logic [1:0] {
      BST_ARM  = 2'b00,
      BST_HIGH = 2'b01,
      BST_LOW  = 2'b10
   } bst_e;

   localparam int NUM_RATES = 4;

   function automatic int rate_hz(input int rate_idx);
      case (rate_idx)
         0:       return 100;
         1:       return 50;
         2:       return 10;
         default: return 1;
      endcase
   endfunction

   // Clamped to 1 so a tiny CLK_HZ still yields a legal divider.
   function automatic int half_period(input int clk_hz, input int rate_idx);
      int h;
      h = clk_hz / (2 * rate_hz(rate_idx));
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/led_rate_div.sv
// Free-running divider: one-cycle tick every H cycles, toggle flips on each tick.
module led_rate_div
   import led_blink_pkg::*;
#(
   parameter int H = 125
) (
   input  logic i_clock,
   input  logic i_reset_n,
   output logic o_tick,
   output logic o_toggle
);

   localparam int            CW   = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] LAST = CW'(H - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tgl_q, tgl_d;

   always_comb begin
      o_tick = (cnt_q == LAST);
      cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
      tgl_d  = tgl_q ^ o_tick;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
         tgl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tgl_q <= tgl_d;
      end
   end

   assign o_toggle = tgl_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared rate dividers feed per-channel OFF/ON/BLINK/BURST logic.
module led_blink_multi
   import led_blink_pkg::*;
#(
   parameter int CLK_HZ = 25000,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic              i_cfg_we,
   input  logic [3:0]        i_cfg_ch,
   input  logic [1:0]        i_cfg_mode,
   input  logic [1:0]        i_cfg_rate,
   input  logic [CNT_W-1:0]  i_cfg_count,
   output logic [NUM_CH-1:0] o_led,
   output logic [NUM_CH-1:0] o_busy,
   output logic [NUM_CH-1:0] o_done
);

   logic [NUM_RATES-1:0] tick, tgl;

   for (genvar r = 0; r < NUM_RATES; r++) begin : g_div
      led_rate_div #(.H(half_period(CLK_HZ, r))) u_div (
         .i_clock  (i_clock),
         .i_reset_n(i_reset_n),
         .o_tick   (tick[r]),
         .o_toggle (tgl[r])
      );
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mode_e            mode_q, mode_d;
      rate_e            rate_q, rate_d;
      bst_e             bst_q, bst_d;
      logic [CNT_W-1:0] rem_q, rem_d;
      logic             wr, tick_sel, burst_end, drive, led, busy, done;

      assign wr       = i_cfg_we && (i_cfg_ch == 4'(c));
      assign tick_sel = tick[rate_q];

      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            mode_q <= MODE_OFF;
            rate_q <= RATE_100HZ;
            bst_q  <= BST_ARM;
            rem_q  <= '0;
         end else begin
            mode_q <= mode_d;
            rate_q <= rate_d;
            bst_q  <= bst_d;
            rem_q  <= rem_d;
         end
      end

      // rem_q counts high phases not yet started; a write always overrides burst progress.
      always_comb begin
         mode_d    = mode_q;
         rate_d    = rate_q;
         bst_d     = bst_q;
         rem_d     = rem_q;
         burst_end = 1'b0;
         if (mode_q == MODE_BURST) begin
            case (bst_q)
               BST_ARM: begin
                  if (rem_q == '0) begin
                     burst_end = 1'b1;
                  end else if (tick_sel) begin
                     bst_d = BST_HIGH;
                     rem_d = rem_q - 1'b1;
                  end
               end
               BST_HIGH: if (tick_sel) bst_d = BST_LOW;
               BST_LOW: begin
                  if (tick_sel) begin
                     if (rem_q != '0) begin
                        bst_d = BST_HIGH;
                        rem_d = rem_q - 1'b1;
                     end else begin
                        burst_end = 1'b1;
                     end
                  end
               end
               default: bst_d = BST_ARM;
            endcase
         end
         if (burst_end) mode_d = MODE_OFF;
         if (wr) begin
            mode_d = mode_e'(i_cfg_mode);
            rate_d = rate_e'(i_cfg_rate);
            rem_d  = i_cfg_count;
            bst_d  = BST_ARM;
         end
      end

      always_comb begin
         case (mode_q)
            MODE_ON:    drive = 1'b1;
            MODE_BLINK: drive = tgl[rate_q];
            MODE_BURST: drive = (bst_q == BST_HIGH);
            default:    drive = 1'b0;
         endcase
         led  = drive & i_enable;
         busy = (mode_q == MODE_BURST);
         done = burst_end & ~wr;
      end

      assign o_led[c]  = led;
      assign o_busy[c] = busy;
      assign o_done[c] = done;
   end

endmodule

// File: tb/tb_led_blink_multi.sv
// Scoreboard bench: stimulus queues expected output-change events, monitor checks each change.
module tb_led_blink_multi;
   import led_blink_pkg::*;

   logic       clk = 1'b0, rst_n = 1'b1, en = 1'b1, we = 1'b0;
   logic [3:0] ch = '0;
   logic [1:0] md = '0, rt = '0;
   logic [7:0] cnt = '0;
   logic [3:0] led, busy, done;

   int ecnt = 0;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      string       name;
      int          cyc;
      logic [11:0] val;
   } exp_t;
   exp_t        exp_q[$];
   logic [11:0] prev = '0;

   always #5 clk = ~clk;

   led_blink_multi #(.CLK_HZ(25000), .NUM_CH(4), .CNT_W(8)) dut (
      .i_clock    (clk),
      .i_reset_n  (rst_n),
      .i_enable   (en),
      .i_cfg_we   (we),
      .i_cfg_ch   (ch),
      .i_cfg_mode (md),
      .i_cfg_rate (rt),
      .i_cfg_count(cnt),
      .o_led      (led),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Edge index since reset release: sample at negedge after edge k reads k.
   always @(posedge clk) ecnt <= rst_n ? ecnt + 1 : 0;

   always @(negedge clk) begin
      logic [11:0] cur;
      exp_t        e;
      cur = {led, busy, done};
      if (cur !== prev) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: cyc %0d led/busy/done %b, none required", ecnt, cur);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != ecnt || e.val !== cur) begin
               n_fail++;
               $display("FAIL %s: got cyc %0d led/busy/done %b, required cyc %0d %b",
                        e.name, ecnt, cur, e.cyc, e.val);
            end
         end
         prev = cur;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", ecnt);
      $fatal(1, "watchdog");
   end

   function automatic void push(input string nm, input int c,
                                input logic [3:0] l, input logic [3:0] b, input logic [3:0] d);
      exp_t e;
      e.name = nm; e.cyc = c; e.val = {l, b, d};
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, got, req);
      end
   endtask

   // Config loads on edge w.
   task automatic wr_at(input int w, input logic [3:0] c, input logic [1:0] m,
                        input logic [1:0] r, input logic [7:0] n);
      if (ecnt >= w) chk("late_write", 32'(ecnt), 32'(w - 1));
      while (ecnt < w - 1) begin @(posedge clk); #2; end
      we = 1'b1; ch = c; md = m; rt = r; cnt = n;
      @(posedge clk); #2;
      we = 1'b0;
   endtask

   // Returns just after edge n, so a combinational change shows at sample n.
   task automatic at(input int n);
      if (ecnt > n) chk("late_step", 32'(ecnt), 32'(n));
      while (ecnt < n) begin @(posedge clk); #2; end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outputs", 32'({led, busy, done}), 32'h0);
      rst_n = 1'b1;

      // BLINK 100 Hz: 250-cycle period, 125 high, first tick 125 after release
      push("blink_r0_rise1", 125, 4'b0001, 4'b0, 4'b0);
      push("blink_r0_fall",  250, 4'b0000, 4'b0, 4'b0);
      push("blink_r0_rise2", 375, 4'b0001, 4'b0, 4'b0);
      wr_at(10, 4'd0, MODE_BLINK, 2'd0, 8'd0);
      push("blink_off", 400, 4'b0000, 4'b0, 4'b0);
      wr_at(400, 4'd0, MODE_OFF, 2'd0, 8'd0);

      // BURST count 3 on ch1
      push("burst3_arm",   410, 4'b0000, 4'b0010, 4'b0);
      push("burst3_hi1",   500, 4'b0010, 4'b0010, 4'b0);
      push("burst3_lo1",   625, 4'b0000, 4'b0010, 4'b0);
      push("burst3_hi2",   750, 4'b0010, 4'b0010, 4'b0);
      push("burst3_lo2",   875, 4'b0000, 4'b0010, 4'b0);
      push("burst3_hi3",  1000, 4'b0010, 4'b0010, 4'b0);
      push("burst3_lo3",  1125, 4'b0000, 4'b0010, 4'b0);
      push("burst3_done", 1249, 4'b0000, 4'b0010, 4'b0010);
      push("burst3_idle", 1250, 4'b0000, 4'b0000, 4'b0);
      wr_at(410, 4'd1, MODE_BURST, 2'd0, 8'd3);

      // BURST count 0 ends immediately
      push("burst0_done", 1300, 4'b0000, 4'b0100, 4'b0100);
      push("burst0_idle", 1301, 4'b0000, 4'b0000, 4'b0);
      wr_at(1300, 4'd2, MODE_BURST, 2'd0, 8'd0);

      // Mid-burst rewrite to ON: no done pulse
      push("rewr_arm",  1310, 4'b0000, 4'b1000, 4'b0);
      push("rewr_hi",   1500, 4'b1000, 4'b1000, 4'b0);
      push("rewr_lo",   1750, 4'b0000, 4'b1000, 4'b0);
      wr_at(1310, 4'd3, MODE_BURST, 2'd1, 8'd5);
      push("rewr_on",   1800, 4'b1000, 4'b0000, 4'b0);
      wr_at(1800, 4'd3, MODE_ON, 2'd0, 8'd0);
      push("rewr_off",  1810, 4'b0000, 4'b0000, 4'b0);
      wr_at(1810, 4'd3, MODE_OFF, 2'd0, 8'd0);

      // Write landing on the burst-end cycle wins, done suppressed
      push("race_arm", 1820, 4'b0000, 4'b0010, 4'b0);
      push("race_hi",  1875, 4'b0010, 4'b0010, 4'b0);
      push("race_lo",  2000, 4'b0000, 4'b0010, 4'b0);
      wr_at(1820, 4'd1, MODE_BURST, 2'd0, 8'd1);
      push("race_on",  2125, 4'b0010, 4'b0000, 4'b0);
      wr_at(2125, 4'd1, MODE_ON, 2'd0, 8'd0);
      push("race_off", 2130, 4'b0000, 4'b0000, 4'b0);
      wr_at(2130, 4'd1, MODE_OFF, 2'd0, 8'd0);

      // Out-of-range channel is ignored
      wr_at(2140, 4'd5, MODE_ON, 2'd0, 8'd0);

      // All channels BLINK, gated by enable, phase kept
      push("all_ch0", 2150, 4'b0001, 4'b0, 4'b0);
      push("all_ch1", 2151, 4'b0011, 4'b0, 4'b0);
      push("all_ch2", 2152, 4'b0111, 4'b0, 4'b0);
      push("all_ch3", 2153, 4'b1111, 4'b0, 4'b0);
      push("all_fall", 2250, 4'b0000, 4'b0, 4'b0);
      push("all_rise", 2375, 4'b1111, 4'b0, 4'b0);
      for (int i = 0; i < 4; i++) wr_at(2150 + i, 4'(i), MODE_BLINK, 2'd0, 8'd0);
      push("en_off", 2400, 4'b0000, 4'b0, 4'b0);
      at(2400); en = 1'b0;
      push("en_on",   2700, 4'b1111, 4'b0, 4'b0);
      push("en_fall", 2750, 4'b0000, 4'b0, 4'b0);
      at(2700); en = 1'b1;
      for (int i = 0; i < 4; i++) wr_at(2760 + i, 4'(i), MODE_OFF, 2'd0, 8'd0);

      // Reset mid-burst aborts without done
      push("rst_arm",   2800, 4'b0000, 4'b0010, 4'b0);
      push("rst_hi",    2875, 4'b0010, 4'b0010, 4'b0);
      push("rst_abort", 2900, 4'b0000, 4'b0000, 4'b0);
      wr_at(2800, 4'd1, MODE_BURST, 2'd0, 8'd2);
      at(2900); rst_n = 1'b0;
      #1 chk("reset_async", 32'({led, busy, done}), 32'h0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // BLINK 1 Hz after fresh reset: 25000-cycle period
      push("blink_r3_rise1", 12500, 4'b0100, 4'b0, 4'b0);
      push("blink_r3_fall",  25000, 4'b0000, 4'b0, 4'b0);
      push("blink_r3_rise2", 37500, 4'b0100, 4'b0, 4'b0);
      wr_at(100, 4'd2, MODE_BLINK, 2'd3, 8'd0);
      push("blink_r3_off", 37600, 4'b0000, 4'b0, 4'b0);
      wr_at(37600, 4'd2, MODE_OFF, 2'd0, 8'd0);

      at(37700);
      chk("events_outstanding", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
